mcu_mailbox: RTL

//  Parametrised MCU<->fabric mailbox between the MCU GPIO pair (from_mcu/to_mcu) and the DDS control path.

---
 rtl/mcu_mailbox.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mcu_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : mcu_mailbox
// Purpose  : Mailbox between the MCU GPIO pair and the DDS control path.
//            Signed frequency-change samples are buffered in a FIFO, and each
//            accepted sample raises an irq pulse. One-shot MCU commands pop a
//            sample, load the DDS phase increment (with a timed load strobe)
//            or clear the sticky status flags.
// Ports    : aclk            - system clock (single domain)
//            reset           - synchronous active-high reset
//            fq_change       - signed 8-bit frequency-change sample
//            fq_change_valid - push strobe, one sample per cycle high
//            from_mcu        - MCU command word: [31:28] cmd, [27:0] data
//            to_mcu          - registered response word
//            phase_inc       - DDS phase increment
//            phase_inc_valid - DDS load strobe, STROBE_CYCLES wide
//            irq             - retriggerable pulse per accepted push
//            irq_pending     - high while the FIFO holds data
//            fifo_level      - number of FIFO entries
// Options  : define MCU_MAILBOX_TIMESTAMP_EN to store a 16-bit free-running
//            timestamp with every sample and return it in to_mcu[23:8].
// Revision : 1.0 - initial release
// ============================================================================
module mcu_mailbox #(
  parameter int unsigned PHASE_INC_WIDTH = 27,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned IRQ_CYCLES      = 4,
  parameter int unsigned STROBE_CYCLES   = 2
) (
  input  logic                         aclk,
  input  logic                         reset,
  input  logic [7:0]                   fq_change,
  input  logic                         fq_change_valid,
  input  logic [31:0]                  from_mcu,
  output logic [31:0]                  to_mcu,
  output logic [PHASE_INC_WIDTH-1:0]   phase_inc,
  output logic                         phase_inc_valid,
  output logic                         irq,
  output logic                         irq_pending,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int unsigned c_AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned c_LW    = c_AW + 1;
  localparam int unsigned c_IRQ_W = $clog2(IRQ_CYCLES + 1);
  localparam int unsigned c_STB_W = $clog2(STROBE_CYCLES + 1);

  localparam logic [c_LW-1:0]    c_FULL      = c_LW'(FIFO_DEPTH);
  localparam logic [c_IRQ_W-1:0] c_IRQ_LOAD  = c_IRQ_W'(IRQ_CYCLES);
  localparam logic [c_STB_W-1:0] c_STB_LOAD  = c_STB_W'(STROBE_CYCLES);

  localparam logic [3:0] c_CMD_NOP = 4'd0;
  localparam logic [3:0] c_CMD_GET = 4'd1;
  localparam logic [3:0] c_CMD_SET = 4'd2;
  localparam logic [3:0] c_CMD_CLR = 4'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                       armed_q, armed_d;
  logic [31:0]                resp_q, resp_d;
  logic                       ovf_q, ovf_d;
  logic                       ill_q, ill_d;
  logic [c_LW-1:0]            level_q, level_d;
  logic [c_AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [c_AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [7:0]                 mem_q [FIFO_DEPTH];
  logic [7:0]                 mem_d [FIFO_DEPTH];
  logic [PHASE_INC_WIDTH-1:0] phase_q, phase_d;
  logic [c_STB_W-1:0]         stb_cnt_q, stb_cnt_d;
  logic [c_IRQ_W-1:0]         irq_cnt_q, irq_cnt_d;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [3:0]  w_cmd;
  logic [27:0] w_data;
  logic        w_unused_data;
  logic        w_accept, w_get, w_set, w_clr, w_ill;
  logic        w_full, w_pop, w_push, w_drop;
  logic [15:0] w_head_ts;

  assign w_cmd  = from_mcu[31:28];
  assign w_data = from_mcu[27:0];
  // Data bits above the phase increment width carry no meaning.
  assign w_unused_data = ^w_data;

  // A command fires once on its first armed cycle; only a NOP re-arms, so a
  // held or directly changed command word never fires a second time.
  assign w_accept = armed_q && (w_cmd != c_CMD_NOP);
  assign w_get    = w_accept && (w_cmd == c_CMD_GET);
  assign w_set    = w_accept && (w_cmd == c_CMD_SET);
  assign w_clr    = w_accept && (w_cmd == c_CMD_CLR);
  assign w_ill    = w_accept && (w_cmd > c_CMD_CLR);

  assign w_full = (level_q == c_FULL);
  assign w_pop  = w_get && (level_q != '0);
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_push = fq_change_valid && (!w_full || w_pop);
  assign w_drop = fq_change_valid && w_full && !w_pop;

  // --------------------------------------------------------------------------
  // Optional timestamp storage
  // --------------------------------------------------------------------------
`ifdef MCU_MAILBOX_TIMESTAMP_EN
  logic [15:0] ts_q, ts_d;
  logic [15:0] ts_mem_q [FIFO_DEPTH];
  logic [15:0] ts_mem_d [FIFO_DEPTH];

  always_comb begin
    ts_d     = ts_q + 16'd1;
    ts_mem_d = ts_mem_q;
    if (w_push) begin
      ts_mem_d[wr_ptr_q] = ts_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      ts_q     <= '0;
      ts_mem_q <= '{default: '0};
    end else begin
      ts_q     <= ts_d;
      ts_mem_q <= ts_mem_d;
    end
  end

  assign w_head_ts = ts_mem_q[rd_ptr_q];
`else
  assign w_head_ts = 16'd0;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    armed_d   = armed_q;
    resp_d    = resp_q;
    ovf_d     = ovf_q;
    ill_d     = ill_q;
    level_d   = level_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_d     = mem_q;
    phase_d   = phase_q;
    stb_cnt_d = stb_cnt_q;
    irq_cnt_d = irq_cnt_q;

    // Handshake
    if (w_cmd == c_CMD_NOP) begin
      armed_d = 1'b1;
    end else if (w_accept) begin
      armed_d = 1'b0;
    end

    // Sticky flags: a clear accepted in the same cycle as a new event wins.
    if (w_clr) begin
      ovf_d = 1'b0;
      ill_d = 1'b0;
    end else begin
      ovf_d = ovf_q | w_drop;
      ill_d = ill_q | w_ill;
    end

    // FIFO
    if (w_push) begin
      mem_d[wr_ptr_q] = fq_change;
      wr_ptr_d        = wr_ptr_q + c_AW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_AW'(1);
    end
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + c_LW'(1);
      2'b01:   level_d = level_q - c_LW'(1);
      default: level_d = level_q;
    endcase

    // Response word; fields not touched by a command keep their last value.
    if (w_accept) begin
      resp_d[31:28] = w_cmd;
      resp_d[27]    = ovf_d;
      resp_d[25]    = ill_d;
      resp_d[24]    = 1'b0;
      if (w_get) begin
        resp_d[26]   = w_pop;
        resp_d[23:8] = w_pop ? w_head_ts : 16'd0;
        resp_d[7:0]  = w_pop ? mem_q[rd_ptr_q] : 8'd0;
      end
    end

    // Phase increment load and strobe (a reload restarts the full strobe)
    if (w_set) begin
      phase_d   = w_data[PHASE_INC_WIDTH-1:0];
      stb_cnt_d = c_STB_LOAD;
    end else if (stb_cnt_q != '0) begin
      stb_cnt_d = stb_cnt_q - c_STB_W'(1);
    end

    // irq pulse, retriggered by every stored sample
    if (w_push) begin
      irq_cnt_d = c_IRQ_LOAD;
    end else if (irq_cnt_q != '0) begin
      irq_cnt_d = irq_cnt_q - c_IRQ_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (reset) begin
      armed_q   <= 1'b1;
      resp_q    <= '0;
      ovf_q     <= 1'b0;
      ill_q     <= 1'b0;
      level_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_q     <= '{default: '0};
      phase_q   <= '0;
      stb_cnt_q <= '0;
      irq_cnt_q <= '0;
    end else begin
      armed_q   <= armed_d;
      resp_q    <= resp_d;
      ovf_q     <= ovf_d;
      ill_q     <= ill_d;
      level_q   <= level_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_q     <= mem_d;
      phase_q   <= phase_d;
      stb_cnt_q <= stb_cnt_d;
      irq_cnt_q <= irq_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all derived directly from registers)
  // --------------------------------------------------------------------------
  assign to_mcu          = resp_q;
  assign phase_inc       = phase_q;
  assign phase_inc_valid = (stb_cnt_q != '0);
  assign irq             = (irq_cnt_q != '0);
  assign irq_pending     = (level_q != '0);
  assign fifo_level      = level_q;

endmodule
`default_nettype wire
